// File: rtl/core_pkg.sv
// Shared core definitions: reset/NOP defaults, fetch FSM encoding and the IF/ID payload.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 2;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK    = 32'hFFFF_FFFC;

    localparam logic [STATE_W-1:0] ST_FETCH = 2'b00;
    localparam logic [STATE_W-1:0] ST_HOLD  = 2'b01;
    localparam logic [STATE_W-1:0] ST_DROP  = 2'b10;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for a response that arrives while decode is stalled.
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] wr_instr,
    input  logic [XLEN-1:0] wr_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic            full
);

    // Clear wins over load so a redirect always empties the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= '0;
            pc    <= '0;
            full  <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            instr <= wr_instr;
            pc    <= wr_pc;
            full  <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request handshake and loads IF/ID.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_F,
    input  logic            stall_D,
    input  logic            flush_D,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr_D,
    output logic [XLEN-1:0] pc_D,
    output logic [XLEN-1:0] pc4_D,
    output logic            valid_D
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam ifid_t           IFID_RESET = '{instr: NOP_INSTR, pc: '0, pc4: PC_STEP, valid: 1'b0};

    logic [STATE_W-1:0] state, state_nxt;
    logic [XLEN-1:0]    pc_f, pc_nxt;
    logic [XLEN-1:0]    old_addr, old_addr_nxt;
    logic [XLEN-1:0]    target;
    ifid_t              ifid, ifid_nxt;
    logic               req;
    logic               skid_load, skid_clear, skid_full;
    logic [XLEN-1:0]    skid_instr, skid_pc;

    assign target = word_align(jump_target);

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clear    (skid_clear),
        .wr_instr (imem_rdata),
        .wr_pc    (pc_f),
        .instr    (skid_instr),
        .pc       (skid_pc),
        .full     (skid_full)
    );

    // Request side: DROP keeps presenting the abandoned address until memory answers.
    always_comb begin
        req       = 1'b0;
        imem_addr = pc_f;
        case (state)
            ST_FETCH: req = !stall_F;
            ST_DROP: begin
                req       = 1'b1;
                imem_addr = old_addr;
            end
            default: ;
        endcase
    end

    assign imem_req = req && !reset;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_f;
        old_addr_nxt = old_addr;
        ifid_nxt     = ifid;
        skid_load    = 1'b0;
        skid_clear   = 1'b0;

        // Decode consumes IF/ID whenever it is not stalled; refill with a bubble by default.
        if (!stall_D) begin
            ifid_nxt.instr = NOP_INSTR;
            ifid_nxt.valid = 1'b0;
        end

        case (state)
            ST_FETCH: begin
                if (jump_en) begin
                    pc_nxt = target;
                    if (req && !imem_ready) begin
                        old_addr_nxt = pc_f;
                        state_nxt    = ST_DROP;
                    end
                end else if (req && imem_ready) begin
                    pc_nxt = pc_f + PC_STEP;
                    if (!stall_D) begin
                        ifid_nxt = '{instr: imem_rdata, pc: pc_f, pc4: pc_f + PC_STEP, valid: 1'b1};
                    end else if (!flush_D) begin
                        skid_load = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (jump_en || flush_D) begin
                    skid_clear = 1'b1;
                    state_nxt  = ST_FETCH;
                    if (jump_en) begin
                        pc_nxt = target;
                    end
                end else if (!stall_D || !skid_full) begin
                    ifid_nxt   = '{instr: skid_instr, pc: skid_pc, pc4: skid_pc + PC_STEP, valid: skid_full};
                    skid_clear = 1'b1;
                    state_nxt  = ST_FETCH;
                end
            end
            ST_DROP: begin
                if (jump_en) begin
                    pc_nxt = target;
                end
                if (imem_ready) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase

        if (flush_D) begin
            ifid_nxt.instr = NOP_INSTR;
            ifid_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FETCH;
            pc_f     <= word_align(RESET_PC);
            old_addr <= word_align(RESET_PC);
            ifid     <= IFID_RESET;
        end else begin
            state    <= state_nxt;
            pc_f     <= pc_nxt;
            old_addr <= old_addr_nxt;
            ifid     <= ifid_nxt;
        end
    end

    assign instr_D = ifid.instr;
    assign pc_D    = ifid.pc;
    assign pc4_D   = ifid.pc4;
    assign valid_D = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a wait-state memory model and an IF/ID scoreboard.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall_F, stall_D, flush_D, jump_en;
    logic [31:0] jump_target;
    logic        imem_req, imem_ready, valid_D;
    logic [31:0] imem_addr, imem_rdata, instr_D, pc_D, pc4_D;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4;

    int unsigned mem_lat;
    int unsigned wcnt;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D),
        .jump_en(jump_en), .jump_target(jump_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr_D(instr_D), .pc_D(pc_D),
        .pc4_D(pc4_D), .valid_D(valid_D)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .stall_F(1'b0), .stall_D(1'b0), .flush_D(1'b0),
        .jump_en(1'b0), .jump_target(32'h0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(w_req), .imem_rdata(w_addr | 32'h1), .instr_D(w_instr), .pc_D(w_pc),
        .pc4_D(w_pc4), .valid_D(w_valid)
    );

    // Memory answers after mem_lat cycles of a held request, with data = addr | 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wcnt <= 0;
        else if (imem_req && !imem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end
    assign imem_ready = imem_req && (wcnt + 1 >= mem_lat);
    assign imem_rdata = imem_ready ? (imem_addr | 32'h1) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic consume();
        logic [63:0] e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_extra observed instr=%h pc=%h expected none", instr_D, pc_D);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_instr", instr_D, e[63:32]);
            chk("sb_pc", pc_D, e[31:0]);
            chk("sb_pc4", pc4_D, e[31:0] + 32'd4);
        end
    endtask

    // Decode takes IF/ID at the next edge when it is valid and neither stalled nor flushed.
    task automatic tick();
        @(negedge clk);
        if (valid_D && !stall_D && !flush_D) consume();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a, input logic need_ready, input int maxc);
        int n = 0;
        while (!(imem_req && imem_addr == a && (imem_ready || !need_ready)) && n < maxc) begin
            tick();
            n++;
        end
        checks++;
        assert (imem_req && imem_addr == a && (imem_ready || !need_ready)) else begin
            errors++;
            $error("FAIL %s timeout observed addr=%h expected addr=%h", tag, imem_addr, a);
        end
    endtask

    task automatic apply_reset(input int unsigned lat);
        reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
        jump_en = 1'b0; jump_target = 32'h0; mem_lat = lat;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall_F = 1'b0; stall_D = 1'b0; flush_D = 1'b0;
        jump_en = 1'b0; jump_target = 32'h0; mem_lat = 1;
        @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr_D, 32'h13);
        chk("rst_pc", pc_D, 32'h0);
        chk("rst_pc4", pc4_D, 32'h4);
        chk("rst_valid", 32'(valid_D), 32'd0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);

        // Zero-wait streaming, plus the wrapping instance alongside.
        exp_q.push_back({32'h1, 32'h0});
        exp_q.push_back({32'h5, 32'h4});
        exp_q.push_back({32'h9, 32'h8});
        apply_reset(1);
        chk("s1_addr0", imem_addr, 32'h0);
        chk("s1_req0", 32'(imem_req), 32'd1);
        chk("s1_valid0", 32'(valid_D), 32'd0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFF8);
        tick();
        chk("s1_addr1", imem_addr, 32'h4);
        chk("s1_instr1", instr_D, 32'h1);
        chk("s1_valid1", 32'(valid_D), 32'd1);
        chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
        tick();
        chk("s1_addr2", imem_addr, 32'h8);
        chk("wrap_addr2", w_addr, 32'h0);
        chk("wrap_instr", w_instr, 32'hFFFF_FFFD);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0);
        chk("wrap_valid", 32'(w_valid), 32'd1);
        tick();
        chk("s1_addr3", imem_addr, 32'hC);
        stall_F = 1'b1;
        tick();
        tick();

        // Decode stall during a 2-cycle response lands in the skid buffer.
        exp_q.push_back({32'h1, 32'h0});
        exp_q.push_back({32'h5, 32'h4});
        exp_q.push_back({32'h9, 32'h8});
        exp_q.push_back({32'hD, 32'hC});
        apply_reset(2);
        wait_addr("s2_wait8", 32'h8, 1'b1, 20);
        stall_D = 1'b1;
        tick();
        chk("hold_req0", 32'(imem_req), 32'd0);
        tick();
        chk("hold_req1", 32'(imem_req), 32'd0);
        tick();
        chk("hold_req2", 32'(imem_req), 32'd0);
        stall_D = 1'b0;
        tick();
        chk("skid_instr", instr_D, 32'h9);
        chk("skid_pc", pc_D, 32'h8);
        chk("skid_valid", 32'(valid_D), 32'd1);
        chk("skid_next_addr", imem_addr, 32'hC);
        chk("skid_next_req", 32'(imem_req), 32'd1);
        wait_addr("s2_waitC", 32'hC, 1'b1, 10);
        tick();
        stall_F = 1'b1;
        tick();
        tick();

        // Jump while the 3-cycle request to 0x10 is outstanding.
        exp_q.push_back({32'h1, 32'h0});
        exp_q.push_back({32'h5, 32'h4});
        exp_q.push_back({32'h9, 32'h8});
        exp_q.push_back({32'hD, 32'hC});
        exp_q.push_back({32'h101, 32'h100});
        apply_reset(3);
        wait_addr("s3_wait10", 32'h10, 1'b0, 30);
        tick();
        jump_en = 1'b1;
        jump_target = 32'h100;
        tick();
        jump_en = 1'b0;
        chk("drop_addr", imem_addr, 32'h10);
        chk("drop_req", 32'(imem_req), 32'd1);
        tick();
        chk("post_drop_addr", imem_addr, 32'h100);
        chk("post_drop_valid", 32'(valid_D), 32'd0);
        chk("post_drop_instr", instr_D, 32'h13);
        wait_addr("s3_wait100", 32'h100, 1'b1, 10);
        tick();
        chk("jump_pc_D", pc_D, 32'h100);
        stall_F = 1'b1;
        tick();
        tick();

        // Flush together with decode stall, then a jump while fetch is stalled.
        exp_q.push_back({32'h201, 32'h200});
        apply_reset(1);
        tick();
        chk("pre_flush_instr", instr_D, 32'h1);
        flush_D = 1'b1;
        stall_D = 1'b1;
        tick();
        chk("flush_instr", instr_D, 32'h13);
        chk("flush_valid", 32'(valid_D), 32'd0);
        chk("flush_pc_adv", imem_addr, 32'h8);
        flush_D = 1'b0;
        stall_D = 1'b0;
        stall_F = 1'b1;
        jump_en = 1'b1;
        jump_target = 32'h203;
        tick();
        chk("stallF_jump_addr", imem_addr, 32'h200);
        chk("stallF_jump_req", 32'(imem_req), 32'd0);
        jump_en = 1'b0;
        stall_F = 1'b0;
        tick();
        chk("stallF_jump_pc_D", pc_D, 32'h200);
        stall_F = 1'b1;
        tick();
        tick();

        // Asynchronous reset between edges while in DROP.
        apply_reset(3);
        wait_addr("s6_wait0", 32'h0, 1'b1, 10);
        tick();
        stall_D = 1'b1;
        jump_en = 1'b1;
        jump_target = 32'h40;
        tick();
        jump_en = 1'b0;
        chk("s6_drop_addr", imem_addr, 32'h4);
        chk("s6_drop_valid", 32'(valid_D), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_valid", 32'(valid_D), 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_instr", instr_D, 32'h13);
        tick();
        stall_D = 1'b0;
        exp_q.push_back({32'h1, 32'h0});
        reset = 1'b0;
        #1;
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        wait_addr("s6_wait0b", 32'h0, 1'b1, 10);
        tick();
        chk("post_rst_instr", instr_D, 32'h1);
        stall_F = 1'b1;
        tick();
        tick();

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage core: owns the PC, drives the instruction-memory request handshake, and loads the IF/ID pipeline register consumed by decode.
- Obeys stall_F/stall_D/flush_D from the hazard unit.
- Redirects on jump_en/jump_target from execute.
- Includes a one-entry skid buffer so a memory response arriving during a stall is never lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on flush or reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall_F  input  1  hold PC; no new request issued.
- stall_D  input  1  hold IF/ID contents.
- flush_D  input  1  load NOP_INSTR into IF/ID, valid_D=0; overrides stall_D.
- jump_en  input  1  redirect PC this cycle.
- jump_target  input  32  redirect address; bits[1:0] ignored (treated as 0).
- imem_req  output  1  request valid.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req && !imem_ready.
- imem_ready  input  1  response valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  input  32  instruction, valid when imem_ready.
- instr_D  output  32  IF/ID instruction.
- pc_D  output  32  IF/ID PC.
- pc4_D  output  32  IF/ID PC+4.
- valid_D  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset values (asynchronous, active-high; applies mid-transaction):
  - pc_F=RESET_PC, state=FETCH, skid empty.
  - imem_req=0 while reset is high; imem_addr=RESET_PC.
  - instr_D=NOP_INSTR, pc_D=0, pc4_D=4, valid_D=0.
  - In-flight responses are not tracked after reset; memory must also be reset.
- State machine (2-bit encoding):
  - FETCH: imem_req=!stall_F, imem_addr=pc_F.
  - HOLD: imem_req=0; skid buffer full.
  - DROP: imem_req=1, imem_addr=old_addr (the pre-jump address).
- FETCH, on imem_ready:
  - If jump_en: discard response, pc_F<=jump_target.
  - Else if !stall_D: load IF/ID {imem_rdata, pc_F, pc_F+4, 1}, pc_F<=pc_F+4.
  - Else: capture {imem_rdata, pc_F} in skid buffer, pc_F<=pc_F+4, go to HOLD.
- FETCH, request pending (imem_req && !imem_ready) with jump_en: pc_F<=jump_target, latch old_addr, go to DROP.
- FETCH, no request active (stall_F) with jump_en: pc_F<=jump_target, stay in FETCH.
- Throughput and latency:
  - Zero-wait memory gives one instruction per cycle.
  - Fetch at cycle N appears in instr_D at cycle N+1.
- HOLD:
  - When stall_D=0: IF/ID<=skid contents, go to FETCH (request resumes next cycle).
  - jump_en in HOLD: clear skid, pc_F<=jump_target, go to FETCH.
  - flush_D in HOLD: clear skid, go to FETCH.
- DROP: on imem_ready, discard data and go to FETCH with pc_F already = target. A further jump_en in DROP updates pc_F only.
- Simultaneous events:
  - jump_en outranks stall_F and stall_D for PC update.
  - flush_D outranks stall_D and any IF/ID load.
  - The hazard unit never asserts stall_F together with jump_en; if it does, jump still wins.
- Arithmetic: PC increment is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- imem_addr[1:0] is always 2'b00.

Decomposition:
- Shared package core_pkg:
  - NOP_INSTR and RESET_PC defaults.
  - Fetch state encoding constants (FETCH=2'b00, HOLD=2'b01, DROP=2'b10).
- Sub-module fetch_skid_buf:
  - One-entry {instr, pc} buffer with load/clear/full.
  - Instantiated once.
- PC, FSM and IF/ID register stay in fetch_stage.

Test Plan:
- Reset release, zero-wait memory returning rdata=addr|1:
  - imem_addr sequence 0,4,8,C.
  - instr_D=1,5,9 with pc_D matching one cycle later; valid_D=1 from 2nd cycle.
- Stall absorbed in skid buffer:
  - Memory with 2-cycle wait; stall_D=1 asserted during the response at addr 8, held 3 cycles.
  - Response captured in skid; imem_req=0 during HOLD.
  - On release instr_D=rdata(8), pc_D=8; next fetch at C, no duplicate or drop.
- Jump during pending request:
  - 3-cycle memory; jump_en with jump_target=32'h100 one cycle after request to 0x10.
  - imem_addr stays 0x10 until ready; that data is not loaded.
  - Next request at 0x100; pc_D=0x100.
- flush_D and stall_D together: flush_D=1, stall_D=1 -> instr_D=32'h13, valid_D=0; PC still advances per stall_F.
- PC wrap: RESET_PC=32'hFFFF_FFF8, zero-wait memory -> imem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset mid-DROP: reset pulse between clock edges -> imem_req=0 immediately, valid_D=0, first post-reset address RESET_PC.
